// File: rtl/prng_stream_ctrl_pkg.sv
// Shared types for the PRNG256 request/stream controller.
package prng_stream_ctrl_pkg;

  localparam int PREFIX_W = 7;

  typedef logic [63:0]  cr_cnt_t;
  typedef logic [255:0] prng_blk_t;
  typedef logic [15:0]  cr_len_t;

  typedef enum logic [1:0] {
    PSC_IDLE  = 2'd0,
    PSC_ISSUE = 2'd1,
    PSC_DRAIN = 2'd2
  } psc_state_t;

endpackage

// File: rtl/cr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module cr_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  // The requester's credit accounting must make this impossible.
  assert property (@(posedge CLK) disable iff (RST) !(push && full));

endmodule

// File: rtl/prng_stream_ctrl.sv
// Requester for PRNG256: issues one Drdy per block of a job, buffers the
// returned blocks and streams them out over valid/ready.
module prng_stream_ctrl
  import prng_stream_ctrl_pkg::*;
#(
  parameter int PIPELINE   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [PREFIX_W-1:0] req_prefix,
  input  cr_cnt_t             req_cnt,
  input  logic [15:0]         req_len,
  output logic [PREFIX_W-1:0] prng_prefix,
  output cr_cnt_t             prng_cnt,
  output logic                prng_drdy,
  input  logic                prng_dvld,
  input  logic [255:0]        prng_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [255:0]        out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising CLK edge where valid & ready
  // are both high; valid, once raised, holds with stable payload until then.

  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  psc_state_t    state;
  cr_cnt_t       cnt_q;
  cr_len_t       remaining;
  cr_len_t       job_len;
  cr_len_t       pop_cnt;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] fifo_count;
  logic [OW:0]   credit_used;
  logic          fifo_empty;
  logic          req_fire;
  logic          pop;
  logic          ret;
  logic          issue;

  assign req_ready = (state == PSC_IDLE);
  assign busy      = (state != PSC_IDLE);
  assign dbg_state = state;
  assign req_fire  = req_valid & req_ready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid && ((pop_cnt + 16'd1) == job_len);

  // A result with nothing outstanding predates a reset and is discarded.
  assign ret = prng_dvld && (outstanding != '0);

  // Credits cover both blocks in flight and blocks already buffered.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign issue = (state == PSC_ISSUE) && (remaining != '0)
              && (credit_used < (OW+1)'(FIFO_DEPTH))
              && ((PIPELINE != 0) || (outstanding == '0));

  cr_sync_fifo #(
    .WIDTH (256),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (ret),
    .push_data (prng_dout),
    .pop       (pop),
    .rd_data   (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= PSC_IDLE;
      cnt_q       <= '0;
      remaining   <= '0;
      job_len     <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
      prng_prefix <= '0;
      prng_cnt    <= '0;
      prng_drdy   <= 1'b0;
      done        <= 1'b0;
    end else begin
      done      <= 1'b0;
      prng_drdy <= issue;

      if (issue) begin
        prng_cnt  <= cnt_q;
        cnt_q     <= cnt_q + cr_cnt_t'(1);
        remaining <= remaining - 16'd1;
      end

      if (issue && !ret)      outstanding <= outstanding + OW'(1);
      else if (!issue && ret) outstanding <= outstanding - OW'(1);

      if (pop) pop_cnt <= pop_cnt + 16'd1;

      case (state)
        PSC_IDLE: begin
          if (req_fire) begin
            if (req_len == '0) begin
              done <= 1'b1;
            end else begin
              state       <= PSC_ISSUE;
              prng_prefix <= req_prefix;
              cnt_q       <= req_cnt;
              remaining   <= req_len;
              job_len     <= req_len;
              pop_cnt     <= '0;
            end
          end
        end
        PSC_ISSUE: begin
          if (pop && out_last) begin
            state <= PSC_IDLE;
            done  <= 1'b1;
          end else if ((remaining == '0) || (issue && remaining == 16'd1)) begin
            state <= PSC_DRAIN;
          end
        end
        PSC_DRAIN: begin
          if (pop && out_last) begin
            state <= PSC_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= PSC_IDLE;
      endcase
    end
  end

endmodule
